dmem_resp: RTL
==============

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit RAM words; it is a power of two, 4..1024.
REQ-002 Parameter WAIT, default 2, SHALL set the extra wait cycles per access; valid range 0..15.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_valid  in  1  processor presents an access request.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_we  in  1  1 = write (MemWrite), 0 = read.
REQ-008 req_addr  in  32  byte address (ALUResult).
REQ-009 req_wdata  in  32  store data (WriteData).
REQ-010 resp_valid  out  1  one-cycle response strobe.
REQ-011 resp_rdata  out  32  load data (ReadData); 0 when resp_valid=0 or on a write.
REQ-012 resp_err  out  1  access fault, qualified by resp_valid.
REQ-013 led  out  8  memory-mapped output register (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
- Acceptance: req_valid=1 and req_ready=1 at a clock edge.
- On acceptance, the block captures req_we, req_addr and req_wdata.
REQ-016 IDLE->WAIT on acceptance with WAIT>0; IDLE->RESP on acceptance with WAIT=0; otherwise stay in IDLE.
REQ-017 WAIT SHALL hold for exactly WAIT cycles using a 4-bit down-counter, then go to RESP.
REQ-018 RESP SHALL last one cycle, then go to IDLE.
REQ-019 Latency: if acceptance occurs at edge N, resp_valid SHALL be 1 only during the cycle after edge N+WAIT+1.
- Throughput: one access every WAIT+2 cycles.
REQ-020 A RAM write SHALL commit on the edge entering RESP; the read data SHALL be sampled on the same edge.
REQ-021 The word index SHALL be addr[log2(DEPTH)+1:2].
REQ-022 A fault SHALL be flagged (resp_err=1, no write, resp_rdata=0) when either holds:
- addr[1:0]!=0;
- addr>=4*DEPTH and addr is not the MMIO address.
REQ-023 req_valid while req_ready=0 SHALL be ignored; changes to the inputs after acceptance SHALL have no effect.
REQ-024 A read of a word written by the immediately preceding access SHALL return the new data.

Reset
REQ-025 reset=1 SHALL force all of the following on the next edge, regardless of state:
- state=IDLE, counter=0;
- resp_valid=0, resp_rdata=0, resp_err=0, led=0.
REQ-026 Reset mid-access SHALL abort the access: no response, and no RAM write unless already committed.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro DMEM_RESP_MMIO_EN, when defined, SHALL map byte address 0x0000FF00 to an 8-bit LED register:
- a write stores wdata[7:0] into led;
- a read returns {24'b0, led};
- resp_err=0 for these accesses.
REQ-030 Without DMEM_RESP_MMIO_EN, 0x0000FF00 SHALL be an ordinary out-of-range fault and led SHALL be tied to 0.

Verification
REQ-031 WAIT=2: write addr 0x10, data 0xDEADBEEF accepted at edge 0 -> resp_valid=1 only after edge 3, resp_err=0, resp_rdata=0; a following read of 0x10 -> resp_rdata=0xDEADBEEF.
REQ-032 Misaligned write to 0x12, then read of 0x10 -> first response resp_err=1; word at 0x10 unchanged.
REQ-033 DEPTH=64, read of 0x100 -> resp_err=1, resp_rdata=0.
REQ-034 req_valid held high continuously with WAIT=0 -> acceptances every 2 cycles; req_ready=0 during RESP.
REQ-035 reset asserted during WAIT of a write to 0x20 -> no resp_valid; a later read of 0x20 returns the old value; led=0.
REQ-036 With DMEM_RESP_MMIO_EN: write 0x000000A5 to 0xFF00 -> led=0xA5 after the RESP edge; read of 0xFF00 -> 0x000000A5. Without the macro: same write -> resp_err=1, led=0.

Source files
------------

// File: rtl/dmem_resp_if.sv
// Processor <-> data-memory request/response bundle used by dmem_resp.
// The master side drives the request fields; the slave side answers with
// req_ready and a one-cycle response strobe.
interface dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp: single-port 32-bit data RAM with a fixed, parameterised access
// latency and a one-cycle response strobe.
//   IDLE --accept--> WAIT (WAIT cycles) --> RESP (1 cycle) --> IDLE
// The RAM write commits and the read data is sampled on the edge entering
// RESP; the response is presented in the cycle after RESP.
// Optional feature: define DMEM_RESP_MMIO_EN to map byte address 0x0000FF00
// to an 8-bit LED register; otherwise that address faults and led is 0.
module dmem_resp #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_resp_if.slave bus,
    output logic [7:0] led
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] LIMIT     = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic          accept;
    logic          enter_resp;

    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;

    logic          is_mmio;
    logic          misaligned;
    logic          out_of_range;
    logic          fault;
    logic          ram_we;
    logic [AW-1:0] idx;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   samp_rdata;
    logic          samp_err;

    assign accept        = bus.req_valid && (state == ST_IDLE);
    assign bus.req_ready = (state == ST_IDLE);

    // With WAIT=0 the commit edge is the acceptance edge, so the live request
    // fields are used while still in IDLE and the captured copy afterwards.
    assign cur_we    = (state == ST_IDLE) ? bus.req_we    : cap_we;
    assign cur_addr  = (state == ST_IDLE) ? bus.req_addr  : cap_addr;
    assign cur_wdata = (state == ST_IDLE) ? bus.req_wdata : cap_wdata;

`ifdef DMEM_RESP_MMIO_EN
    localparam logic [31:0] MMIO_ADDR = 32'h0000_FF00;
    assign is_mmio = (cur_addr == MMIO_ADDR);
`else
    assign is_mmio = 1'b0;
`endif

    assign misaligned   = (cur_addr[1:0] != 2'b00);
    assign out_of_range = (cur_addr >= LIMIT) && !is_mmio;
    assign fault        = misaligned || out_of_range;
    assign idx          = cur_addr[AW+1:2];
    assign ram_we       = !reset && enter_resp && cur_we && !fault && !is_mmio;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; flags the edge that enters RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the request on acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_we    <= bus.req_we;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[idx] <= cur_wdata;
        end
    end

    // Sample read data and fault status on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_rdata <= '0;
            samp_err   <= 1'b0;
        end else if (enter_resp) begin
            samp_err <= fault;
            if (fault || cur_we) begin
                samp_rdata <= '0;
            end else if (is_mmio) begin
                samp_rdata <= {24'h000000, led};
            end else begin
                samp_rdata <= mem[idx];
            end
        end
    end

    // Registered one-cycle response, presented the cycle after RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= (state == ST_RESP);
            bus.resp_rdata <= (state == ST_RESP) ? samp_rdata : '0;
            bus.resp_err   <= (state == ST_RESP) && samp_err;
        end
    end

`ifdef DMEM_RESP_MMIO_EN
    // LED register written by an MMIO store on the commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else if (enter_resp && cur_we && is_mmio) begin
            led <= cur_wdata[7:0];
        end
    end
`else
    assign led = '0;
`endif

endmodule
